carfield_addr_map_cfg: RTL and testbench
========================================

// Module: carfield_addr_map_cfg
// PURPOSE
// - Runtime-programmable address map: NumRules rules {idx, start_addr, end_addr}, reset to a compile-time map.
// - Programmed via register bus into shadow registers; atomic commit copies shadow -> active table.
// - Serves address lookups over a valid/ready port with 1-cycle registered result.
// - Replaces fixed localparam maps at the Carfield AXI/reg demux boundary.
// PARAMETERS
// - NumRules      8          number of rules (1..32)
// - AddrWidth     48         lookup/rule address width (33..64)
// - IdxWidth      4          width of rule idx field and resp_idx_o
// - DefaultMap    '0         addr_rule_t [NumRules-1:0], reset value of shadow and active tables
// - MissIdx       '0         idx returned on miss
// - reg_req_t     logic      register bus request type (32-bit data, 4-bit strb)
// - reg_rsp_t     logic      register bus response type
// PORTS
// - clk_i          in   1          clock
// - rst_ni         in   1          asynchronous active-low reset
// - reg_req_i      in   reg_req_t  config register access
// - reg_rsp_o      out  reg_rsp_t  config response (ready, rdata, error)
// - lkp_valid_i    in   1          lookup request valid
// - lkp_ready_o    out  1          lookup request ready
// - lkp_addr_i     in   AddrWidth  address to decode
// - res_valid_o    out  1          result valid
// - res_ready_i    in   1          result accepted
// - res_idx_o      out  IdxWidth   matched rule idx, MissIdx on miss
// - res_hit_o      out  1          1 = some rule matched
// - locked_o       out  1          map locked
// BEHAVIOUR
// - Reset: shadow=active=DefaultMap, locked_o=0, dirty=0, res_valid_o=0, res_idx_o=MissIdx, res_hit_o=0.
// - Reg map (byte offsets): 0x00 CTRL {bit0 COMMIT W1, self-clearing; bit1 LOCK W1S, sticky until reset};
//   0x04 STATUS RO {bit0 DIRTY}; 0x08 NUMRULES RO; rule i at 0x100+0x20*i: +0x0 START_LO, +0x4 START_HI,
//   +0x8 END_LO, +0xC END_HI, +0x10 IDX. HI words use bits [AddrWidth-33:0]; unused bits read 0, writes ignored.
// - Reg bus: reg_rsp_o.ready=1 combinationally; rdata combinational; reads return SHADOW values. wstrb honoured per byte.
// - Any shadow write sets DIRTY; COMMIT copies all shadows to active in one cycle, clears DIRTY next cycle.
// - Locked: writes to rule regs and COMMIT ignored; LOCK rewrite no-op; reads unaffected.
// - Match: start <= addr < end (end exclusive); rule with start >= end never matches; lowest i wins on overlap.
// - Lookup handshake: lkp_ready_o = !res_valid_o || res_ready_i; on lkp_valid_i&&lkp_ready_o result registered
//   next cycle (latency 1, throughput 1/cycle). res_* held stable while res_valid_o && !res_ready_i.
// - Commit and lookup accept in same cycle: lookup uses the PRE-commit active table.
// - Write and COMMIT same access impossible (distinct offsets); commit takes shadow state before that cycle's write? No:
//   a rule write and COMMIT never coincide; commit always copies current shadow registers.
// - Reset mid-operation: pending result dropped, tables revert to DefaultMap, lock cleared.
// CONFIGURATION
// - CARFIELD_ADDR_MAP_ERR_EN defined: reg_rsp_o.error=1 on unmapped offset, on write to RO reg, and on
//   rule/COMMIT write while locked; state unchanged. Undefined: error tied 0, such accesses silently ignored.
// STRUCTURE
// - carfield_pkg: addr_rule_t (parametrised on AddrWidth/IdxWidth), register offset constants
//   (AddrMapCtrlOffs, AddrMapStatusOffs, AddrMapNumRulesOffs, AddrMapRuleBase, AddrMapRuleStride).
// - Sub-module carfield_addr_map_match: combinational priority matcher (table, addr) -> {hit, idx}.
// TESTING
// - Reset, lookup 0x0000_7000_0010 with DefaultMap LLC rule idx=3 [0x7000_0000,0x7002_0000) -> hit=1, idx=3, 1 cycle later.
// - Write rule0 start=0x1_0000_0000 end=0x1_0000_1000 idx=5, no commit; lookup 0x1_0000_0800 -> miss, MissIdx; DIRTY=1;
//   COMMIT -> same lookup hit, idx=5; DIRTY=0.
// - Overlap: rule1 [0x1000,0x3000) idx=2, rule2 [0x2000,0x4000) idx=7; lookup 0x2800 -> idx=2; 0x3000 -> idx=7; 0x4000 -> miss.
// - Backpressure: res_ready_i=0 for 5 cycles with lkp_valid_i=1 -> lkp_ready_o=0, res_* stable; release -> one result/cycle.
// - COMMIT in same cycle as accepted lookup -> that result uses old table, next lookup uses new.
// - Set LOCK, write rule0 and COMMIT -> active/shadow unchanged; error=1 iff CARFIELD_ADDR_MAP_ERR_EN; reset clears lock.

Source files
------------

// File: rtl/carfield_pkg.sv
// Shared types and register offsets for the runtime-programmable Carfield address map.
// Optional error reporting is controlled by CARFIELD_ADDR_MAP_ERR_EN (see carfield_addr_map_cfg).
package carfield_pkg;

    localparam int unsigned AddrMapAddrWidth = 48;
    localparam int unsigned AddrMapIdxWidth  = 4;

    localparam logic [31:0] AddrMapCtrlOffs     = 32'h0000_0000;
    localparam logic [31:0] AddrMapStatusOffs   = 32'h0000_0004;
    localparam logic [31:0] AddrMapNumRulesOffs = 32'h0000_0008;
    localparam logic [31:0] AddrMapRuleBase     = 32'h0000_0100;
    localparam logic [31:0] AddrMapRuleStride   = 32'h0000_0020;

    typedef struct packed {
        logic [AddrMapIdxWidth-1:0]  idx;
        logic [AddrMapAddrWidth-1:0] start_addr;
        logic [AddrMapAddrWidth-1:0] end_addr;
    } addr_rule_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } addr_map_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } addr_map_reg_rsp_t;

    function automatic logic [31:0] apply_wstrb(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [3:0]  wstrb
    );
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/carfield_addr_map_match.sv
// Combinational priority matcher: end-exclusive ranges, lowest rule index wins on overlap.
module carfield_addr_map_match #(
    parameter int unsigned         NumRules  = 8,
    parameter int unsigned         AddrWidth = 48,
    parameter int unsigned         IdxWidth  = 4,
    parameter logic [IdxWidth-1:0] MissIdx   = '0
) (
    input  logic [NumRules-1:0][AddrWidth-1:0] start_i,
    input  logic [NumRules-1:0][AddrWidth-1:0] end_i,
    input  logic [NumRules-1:0][IdxWidth-1:0]  idx_i,
    input  logic [AddrWidth-1:0]               addr_i,
    output logic                               hit_o,
    output logic [IdxWidth-1:0]                idx_o
);

    logic [NumRules-1:0] match;

    // An empty or inverted range (start >= end) can never match.
    for (genvar gi = 0; gi < NumRules; gi++) begin : g_rule
        assign match[gi] = (start_i[gi] < end_i[gi]) &&
                           (addr_i >= start_i[gi]) && (addr_i < end_i[gi]);
    end

    always_comb begin
        hit_o = |match;
        idx_o = MissIdx;
        for (int i = NumRules - 1; i >= 0; i--) begin
            if (match[i]) begin
                idx_o = idx_i[i];
            end
        end
    end

endmodule

// File: rtl/carfield_addr_map_cfg.sv
// Runtime-programmable address map: shadow/active rule tables, register bus, 1-cycle lookup port.
// Define CARFIELD_ADDR_MAP_ERR_EN to report bus errors on bad/RO/locked accesses.
module carfield_addr_map_cfg
    import carfield_pkg::*;
#(
    parameter int unsigned                NumRules   = 8,
    parameter int unsigned                AddrWidth  = 48,
    parameter int unsigned                IdxWidth   = 4,
    parameter type                        rule_t     = addr_rule_t,
    parameter rule_t [NumRules-1:0]       DefaultMap = '0,
    parameter logic [IdxWidth-1:0]        MissIdx    = '0,
    parameter type                        reg_req_t  = addr_map_reg_req_t,
    parameter type                        reg_rsp_t  = addr_map_reg_rsp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  reg_req_t             reg_req_i,
    output reg_rsp_t             reg_rsp_o,
    input  logic                 lkp_valid_i,
    output logic                 lkp_ready_o,
    input  logic [AddrWidth-1:0] lkp_addr_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [IdxWidth-1:0]  res_idx_o,
    output logic                 res_hit_o,
    output logic                 locked_o
);

    localparam int unsigned HiWidth = AddrWidth - 32;

    logic [NumRules-1:0][AddrWidth-1:0] sh_start_q, sh_end_q, act_start_q, act_end_q;
    logic [NumRules-1:0][IdxWidth-1:0]  sh_idx_q, act_idx_q;
    logic                               dirty_q, locked_q;

    logic                res_valid_q, res_hit_q;
    logic [IdxWidth-1:0] res_idx_q;

    // ---------------- register decode ----------------
    logic [31:0] rule_offs;
    logic [4:0]  rule_sel;
    logic [2:0]  rule_field;
    logic        is_ctrl, is_status, is_numrules, is_rule;

    assign rule_offs   = reg_req_i.addr - AddrMapRuleBase;
    assign rule_sel    = rule_offs[9:5];
    assign rule_field  = rule_offs[4:2];
    assign is_ctrl     = (reg_req_i.addr == AddrMapCtrlOffs);
    assign is_status   = (reg_req_i.addr == AddrMapStatusOffs);
    assign is_numrules = (reg_req_i.addr == AddrMapNumRulesOffs);
    assign is_rule     = (reg_req_i.addr >= AddrMapRuleBase) && (rule_offs[1:0] == 2'b00) &&
                         (rule_offs[31:5] < 27'(NumRules)) && (rule_field <= 3'd4);

    logic [AddrWidth-1:0] rd_start, rd_end;
    logic [IdxWidth-1:0]  rd_idx;
    logic [31:0]          rule_rdata;

    always_comb begin
        rd_start = '0;
        rd_end   = '0;
        rd_idx   = '0;
        for (int i = 0; i < NumRules; i++) begin
            if (rule_sel == 5'(i)) begin
                rd_start = sh_start_q[i];
                rd_end   = sh_end_q[i];
                rd_idx   = sh_idx_q[i];
            end
        end
        case (rule_field)
            3'd0:    rule_rdata = rd_start[31:0];
            3'd1:    rule_rdata = 32'(rd_start[AddrWidth-1:32]);
            3'd2:    rule_rdata = rd_end[31:0];
            3'd3:    rule_rdata = 32'(rd_end[AddrWidth-1:32]);
            3'd4:    rule_rdata = 32'(rd_idx);
            default: rule_rdata = '0;
        endcase
    end

    logic [31:0] rdata;
    logic        acc_err, commit, lock_set, rule_we;

    always_comb begin
        rdata    = '0;
        acc_err  = 1'b0;
        commit   = 1'b0;
        lock_set = 1'b0;
        rule_we  = 1'b0;
        if (reg_req_i.valid) begin
            if (is_ctrl) begin
                rdata = {30'b0, locked_q, 1'b0};
                if (reg_req_i.write && reg_req_i.wstrb[0]) begin
                    if (reg_req_i.wdata[0]) begin
                        if (locked_q) acc_err = 1'b1;
                        else          commit  = 1'b1;
                    end
                    lock_set = reg_req_i.wdata[1];
                end
            end else if (is_status) begin
                rdata   = {31'b0, dirty_q};
                acc_err = reg_req_i.write;
            end else if (is_numrules) begin
                rdata   = 32'(NumRules);
                acc_err = reg_req_i.write;
            end else if (is_rule) begin
                rdata = rule_rdata;
                if (reg_req_i.write) begin
                    if (locked_q) acc_err = 1'b1;
                    else          rule_we = 1'b1;
                end
            end else begin
                acc_err = 1'b1;
            end
        end
    end

`ifdef CARFIELD_ADDR_MAP_ERR_EN
    logic rsp_error;
    assign rsp_error = acc_err;
`else
    logic rsp_error, unused_acc_err;
    assign rsp_error      = 1'b0;
    assign unused_acc_err = acc_err;
`endif

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = 1'b1;
        reg_rsp_o.rdata = rdata;
        reg_rsp_o.error = rsp_error;
    end

    // ---------------- shadow / active tables ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumRules; i++) begin
                sh_start_q[i]  <= AddrWidth'(DefaultMap[i].start_addr);
                sh_end_q[i]    <= AddrWidth'(DefaultMap[i].end_addr);
                sh_idx_q[i]    <= IdxWidth'(DefaultMap[i].idx);
                act_start_q[i] <= AddrWidth'(DefaultMap[i].start_addr);
                act_end_q[i]   <= AddrWidth'(DefaultMap[i].end_addr);
                act_idx_q[i]   <= IdxWidth'(DefaultMap[i].idx);
            end
            dirty_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            if (rule_we) begin
                for (int i = 0; i < NumRules; i++) begin
                    if (rule_sel == 5'(i)) begin
                        case (rule_field)
                            3'd0: sh_start_q[i][31:0] <= apply_wstrb(sh_start_q[i][31:0],
                                      reg_req_i.wdata, reg_req_i.wstrb);
                            3'd1: sh_start_q[i][AddrWidth-1:32] <= HiWidth'(apply_wstrb(
                                      32'(sh_start_q[i][AddrWidth-1:32]), reg_req_i.wdata, reg_req_i.wstrb));
                            3'd2: sh_end_q[i][31:0] <= apply_wstrb(sh_end_q[i][31:0],
                                      reg_req_i.wdata, reg_req_i.wstrb);
                            3'd3: sh_end_q[i][AddrWidth-1:32] <= HiWidth'(apply_wstrb(
                                      32'(sh_end_q[i][AddrWidth-1:32]), reg_req_i.wdata, reg_req_i.wstrb));
                            3'd4: sh_idx_q[i] <= IdxWidth'(apply_wstrb(32'(sh_idx_q[i]),
                                      reg_req_i.wdata, reg_req_i.wstrb));
                            default: ;
                        endcase
                    end
                end
            end
            if (commit) begin
                act_start_q <= sh_start_q;
                act_end_q   <= sh_end_q;
                act_idx_q   <= sh_idx_q;
            end
            if (commit)       dirty_q <= 1'b0;
            else if (rule_we) dirty_q <= 1'b1;
            if (lock_set) locked_q <= 1'b1;
        end
    end

    // ---------------- lookup port ----------------
    logic                m_hit;
    logic [IdxWidth-1:0] m_idx;

    // Matches against the active table as registered, so a same-cycle commit is not yet visible.
    carfield_addr_map_match #(
        .NumRules  (NumRules),
        .AddrWidth (AddrWidth),
        .IdxWidth  (IdxWidth),
        .MissIdx   (MissIdx)
    ) i_match (
        .start_i (act_start_q),
        .end_i   (act_end_q),
        .idx_i   (act_idx_q),
        .addr_i  (lkp_addr_i),
        .hit_o   (m_hit),
        .idx_o   (m_idx)
    );

    assign lkp_ready_o = !res_valid_q || res_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_valid_q <= 1'b0;
            res_hit_q   <= 1'b0;
            res_idx_q   <= MissIdx;
        end else if (lkp_valid_i && lkp_ready_o) begin
            res_valid_q <= 1'b1;
            res_hit_q   <= m_hit;
            res_idx_q   <= m_idx;
        end else if (res_ready_i) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_hit_o   = res_hit_q;
    assign res_idx_o   = res_idx_q;
    assign locked_o    = locked_q;

endmodule

// File: tb/tb_carfield_addr_map_cfg.sv
// Directed self-checking bench for carfield_addr_map_cfg (error checks follow CARFIELD_ADDR_MAP_ERR_EN).
module tb_carfield_addr_map_cfg;
    import carfield_pkg::*;

`ifdef CARFIELD_ADDR_MAP_ERR_EN
    localparam logic ErrEn = 1'b1;
`else
    localparam logic ErrEn = 1'b0;
`endif

    localparam addr_rule_t LlcRule = '{idx: 4'd3, start_addr: 48'h0000_7000_0000,
                                       end_addr: 48'h0000_7002_0000};
    localparam addr_rule_t [7:0] TbMap = {400'b0, LlcRule, 300'b0};

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    addr_map_reg_req_t req;
    addr_map_reg_rsp_t rsp;
    logic              lkp_valid, lkp_ready, res_valid, res_ready, res_hit, locked;
    logic [47:0]       lkp_addr;
    logic [3:0]        res_idx;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    carfield_addr_map_cfg #(
        .NumRules   (8),
        .AddrWidth  (48),
        .IdxWidth   (4),
        .DefaultMap (TbMap),
        .MissIdx    (4'd0)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .reg_req_i   (req),
        .reg_rsp_o   (rsp),
        .lkp_valid_i (lkp_valid),
        .lkp_ready_o (lkp_ready),
        .lkp_addr_i  (lkp_addr),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_idx_o   (res_idx),
        .res_hit_o   (res_hit),
        .locked_o    (locked)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("[%0t] FAIL %s: got %0h, expected %0h", $time, tag, obs, exp);
        end else begin
            $display("[%0t] ok   %s = %0h", $time, tag, obs);
        end
    endtask

    task automatic reg_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, output logic [31:0] rd, output logic err);
        @(negedge clk);
        req.valid = 1'b1;
        req.write = wr;
        req.addr  = a;
        req.wdata = d;
        req.wstrb = s;
        #1;
        rd  = rsp.rdata;
        err = rsp.error;
        @(posedge clk);
        #1;
        req.valid = 1'b0;
        req.write = 1'b0;
    endtask

    task automatic reg_wr(input logic [31:0] a, input logic [31:0] d, output logic err);
        logic [31:0] rd;
        reg_access(1'b1, a, d, 4'hf, rd, err);
    endtask

    task automatic reg_rd(input logic [31:0] a, output logic [31:0] rd, output logic err);
        reg_access(1'b0, a, 32'h0, 4'h0, rd, err);
    endtask

    task automatic wr_rule(input int i, input logic [47:0] s, input logic [47:0] e, input logic [3:0] idx);
        logic err;
        logic [31:0] base;
        base = 32'h100 + 32'h20 * i;
        reg_wr(base + 32'h0,  s[31:0], err);
        reg_wr(base + 32'h4,  32'(s[47:32]), err);
        reg_wr(base + 32'h8,  e[31:0], err);
        reg_wr(base + 32'hC,  32'(e[47:32]), err);
        reg_wr(base + 32'h10, 32'(idx), err);
    endtask

    // Issue one lookup with res_ready high; result is sampled one cycle after acceptance.
    task automatic lookup(input string tag, input logic [47:0] a, input logic exp_hit, input logic [3:0] exp_idx);
        @(negedge clk);
        lkp_valid = 1'b1;
        lkp_addr  = a;
        @(posedge clk);
        #1;
        lkp_valid = 1'b0;
        check({tag, ".valid"}, 64'(res_valid), 64'(1'b1));
        check({tag, ".hit"},   64'(res_hit),   64'(exp_hit));
        check({tag, ".idx"},   64'(res_idx),   64'(exp_idx));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic err;
        req = '0;
        lkp_valid = 1'b0;
        lkp_addr  = '0;
        res_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst.res_valid", 64'(res_valid), 64'(0));
        check("rst.res_hit",   64'(res_hit),   64'(0));
        check("rst.res_idx",   64'(res_idx),   64'(0));
        check("rst.locked",    64'(locked),    64'(0));
        check("rst.lkp_ready", 64'(lkp_ready), 64'(1));
        rst_n = 1'b1;

        reg_rd(32'h8, rd, err);   check("numrules", 64'(rd), 64'(8));
        reg_rd(32'h4, rd, err);   check("status.rst", 64'(rd), 64'(0));
        reg_rd(32'h160, rd, err); check("rule3.start_lo", 64'(rd), 64'h7000_0000);

        lookup("llc", 48'h0000_7000_0010, 1'b1, 4'd3);
        lookup("llc.start", 48'h0000_7000_0000, 1'b1, 4'd3);
        lookup("llc.end", 48'h0000_7002_0000, 1'b0, 4'd0);

        // Program rule0 in shadow only.
        wr_rule(0, 48'h1_0000_0000, 48'h1_0000_1000, 4'd5);
        lookup("pre_commit", 48'h1_0000_0800, 1'b0, 4'd0);
        reg_rd(32'h4, rd, err);   check("status.dirty", 64'(rd), 64'(1));
        reg_rd(32'h104, rd, err); check("rule0.start_hi", 64'(rd), 64'(1));
        reg_access(1'b1, 32'h104, 32'hFFFF_0001, 4'hf, rd, err);
        reg_rd(32'h104, rd, err); check("rule0.hi_mask", 64'(rd), 64'(1));
        reg_access(1'b1, 32'h110, 32'h0000_0F0F, 4'b0010, rd, err);
        reg_rd(32'h110, rd, err); check("rule0.idx_strb", 64'(rd), 64'(5));
        reg_wr(32'h0, 32'h1, err);
        reg_rd(32'h4, rd, err);   check("status.clean", 64'(rd), 64'(0));
        lookup("post_commit", 48'h1_0000_0800, 1'b1, 4'd5);

        // Overlapping rules: lowest index wins.
        wr_rule(1, 48'h1000, 48'h3000, 4'd2);
        wr_rule(2, 48'h2000, 48'h4000, 4'd7);
        reg_wr(32'h0, 32'h1, err);
        lookup("ovl.2800", 48'h2800, 1'b1, 4'd2);
        lookup("ovl.3000", 48'h3000, 1'b1, 4'd7);
        lookup("ovl.4000", 48'h4000, 1'b0, 4'd0);
        lookup("ovl.1000", 48'h1000, 1'b1, 4'd2);

        // Backpressure.
        @(negedge clk);
        res_ready = 1'b0;
        lkp_valid = 1'b1;
        lkp_addr  = 48'h2800;
        @(negedge clk);
        check("bp.first_idx", 64'(res_idx), 64'(2));
        lkp_addr = 48'h3800;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp.lkp_ready", 64'(lkp_ready), 64'(0));
            check("bp.res_valid", 64'(res_valid), 64'(1));
            check("bp.res_idx",   64'(res_idx),   64'(2));
        end
        res_ready = 1'b1;
        #1;
        check("bp.release_ready", 64'(lkp_ready), 64'(1));
        @(negedge clk);
        check("bp.rel1.valid", 64'(res_valid), 64'(1));
        check("bp.rel1.idx",   64'(res_idx),   64'(7));
        lkp_addr = 48'h1800;
        @(negedge clk);
        check("bp.rel2.valid", 64'(res_valid), 64'(1));
        check("bp.rel2.idx",   64'(res_idx),   64'(2));
        lkp_valid = 1'b0;
        @(negedge clk);
        check("bp.drain", 64'(res_valid), 64'(0));

        // Commit and lookup accepted in the same cycle.
        reg_wr(32'h130, 32'h9, err);
        @(negedge clk);
        req.valid = 1'b1; req.write = 1'b1; req.addr = 32'h0; req.wdata = 32'h1; req.wstrb = 4'hf;
        lkp_valid = 1'b1;
        lkp_addr  = 48'h1800;
        @(posedge clk);
        #1;
        req.valid = 1'b0;
        lkp_valid = 1'b0;
        check("cc.old_idx", 64'(res_idx), 64'(2));
        lookup("cc.new", 48'h1800, 1'b1, 4'd9);

        // Lock.
        reg_wr(32'h0, 32'h2, err);
        check("lock.err", 64'(err), 64'(0));
        #1;
        check("lock.locked", 64'(locked), 64'(1));
        reg_wr(32'h110, 32'hA, err); check("lock.rule_err", 64'(err), 64'(ErrEn));
        reg_rd(32'h110, rd, err);    check("lock.shadow", 64'(rd), 64'(5));
        reg_rd(32'h4, rd, err);      check("lock.status", 64'(rd), 64'(0));
        reg_wr(32'h0, 32'h1, err);   check("lock.commit_err", 64'(err), 64'(ErrEn));
        reg_rd(32'h0, rd, err);      check("lock.ctrl_rd", 64'(rd), 64'(2));
        reg_wr(32'h4, 32'h1, err);   check("ro.status_err", 64'(err), 64'(ErrEn));
        reg_rd(32'h40, rd, err);     check("unmapped_err", 64'(err), 64'(ErrEn));
        lookup("lock.lookup", 48'h1_0000_0800, 1'b1, 4'd5);

        // Reset mid-operation with a held result.
        @(negedge clk);
        res_ready = 1'b0;
        lkp_valid = 1'b1;
        lkp_addr  = 48'h2800;
        @(negedge clk);
        lkp_valid = 1'b0;
        check("mid.pending", 64'(res_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid.res_valid", 64'(res_valid), 64'(0));
        check("mid.locked",    64'(locked),    64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        reg_rd(32'h100, rd, err); check("mid.rule0_lo", 64'(rd), 64'(0));
        lookup("mid.old_rule", 48'h1_0000_0800, 1'b0, 4'd0);
        lookup("mid.llc", 48'h0000_7000_0010, 1'b1, 4'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
